// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
// Optional feature macro: UART_ARB_PARITY_EN (even-parity bit between data and stop).
package uart_pkg;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned BIT_IDX_W          = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_ARB_PARITY_EN
    StParity,
`endif
    StStop
  } frame_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         gnt_onehot,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    any
);

  localparam int unsigned IdW = $clog2(NREQ);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant) + k) % NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        gnt_id     = IdW'(idx);
        gnt_onehot = NREQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbitrated UART transmitter: grants one byte requester per frame.
// Define UART_ARB_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(OVERSAMPLE);

  frame_state_e         state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic [IdW-1:0]       last_grant_q;

  logic [NREQ-1:0]      gnt_onehot;
  logic [IdW-1:0]       gnt_id;
  logic                 any_req;
  logic [DATA_BITS-1:0] gnt_byte;
  logic                 bit_end;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .gnt_onehot(gnt_onehot),
    .gnt_id    (gnt_id),
    .any       (any_req)
  );

  always_comb begin
    gnt_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) gnt_byte = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign bit_end = tick && (cnt_q == CntW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tx           <= 1'b1;
      busy         <= 1'b0;
      req_ready    <= '0;
      grant_id     <= '0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      data_q       <= '0;
      last_grant_q <= IdW'(NREQ - 1);
    end else begin
      req_ready <= '0;
      if (state_q != StIdle && tick) cnt_q <= bit_end ? '0 : cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StStart;
            tx           <= 1'b0;
            busy         <= 1'b1;
            req_ready    <= gnt_onehot;
            grant_id     <= gnt_id;
            last_grant_q <= gnt_id;
            data_q       <= gnt_byte;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            tx      <= data_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_ARB_PARITY_EN
              state_q <= StParity;
              tx      <= ^data_q;
`else
              state_q <= StStop;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
              tx        <= data_q[bit_idx_q + BIT_IDX_W'(1)];
            end
          end
        end
`ifdef UART_ARB_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx      <= 1'b1;
          end
        end
`endif
        StStop: begin
          // Back to IDLE for one cycle; a pending request is granted on the next edge.
          if (bit_end) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants/bytes queued by stimulus,
// checked by independent ready and serial-frame monitors.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int OS   = 16;
`ifdef UART_ARB_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameTicks = FrameBits * OS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tick = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx;
  logic              busy;
  logic [1:0]        grant_id;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .OVERSAMPLE(OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_grant[$];
  logic [7:0] exp_byte[$];
  bit expect_b2b = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready monitor: every accept pulse must match the next expected grant.
  always @(negedge clk) begin
    if (!reset && req_ready != '0) begin
      check("ready_onehot", $countones(req_ready), 1);
      if (exp_grant.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got req_ready=%b, expected none", req_ready);
      end else begin
        int id;
        id = exp_grant.pop_front();
        check("ready_id", req_ready, 1 << id);
        check("grant_id", grant_id, id);
      end
    end
  end

  logic tick_last = 1'b0;
  always @(posedge clk) tick_last <= tick;

  // Frame monitor: decodes tx mid-bit, counting only cycles the DUT saw a tick.
  logic [10:0] fbits;
  int consumed, cycle, prev_end;
  bit in_frame = 1'b0, prev_end_valid = 1'b0;
  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      in_frame = 1'b0;
      prev_end_valid = 1'b0;
    end else if (!in_frame) begin
      if (busy) begin
        in_frame = 1'b1;
        consumed = 0;
        fbits = '0;
        if (expect_b2b && prev_end_valid) check("frame_gap", cycle - prev_end, 1);
      end
    end else begin
      consumed += int'(tick_last);
      if (busy && tick_last && (consumed % OS) == OS / 2 && consumed / OS < 11)
        fbits[consumed / OS] = tx;
      if (!busy) begin
        in_frame = 1'b0;
        prev_end = cycle;
        prev_end_valid = 1'b1;
        check("frame_ticks", consumed, FrameTicks);
        check("start_bit", fbits[0], 0);
        check("stop_bit", fbits[FrameBits-1], 1);
        if (exp_byte.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got byte 0x%0h, expected none", fbits[8:1]);
        end else begin
          logic [7:0] b;
          b = exp_byte.pop_front();
          check("frame_data", fbits[8:1], b);
`ifdef UART_ARB_PARITY_EN
          check("parity_bit", fbits[9], ^b);
`endif
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_frame(input int id, input logic [7:0] b);
    exp_grant.push_back(id);
    exp_byte.push_back(b);
  endtask

  task automatic do_reset();
    expect_b2b = 1'b0;
    req_valid = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_state", dut.state_q, StIdle);
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
  endtask

  // Acts as the requesters: drop valid on ready; returns once all served and idle.
  task automatic run_traffic(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      req_valid &= ~req_ready;
      n++;
    end while ((req_valid != '0 || busy) && n < budget);
    check("traffic_done", (req_valid == '0 && !busy), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_bad;
    logic tx_hold;

    // Single byte 0xA5 after reset, one-cycle grant latency.
    do_reset();
    expect_frame(0, 8'hA5);
    set_req(0, 8'hA5);
    @(negedge clk);
    check("ready_latency", req_ready, 4'b0001);
    req_valid &= ~req_ready;
    run_traffic(400);

    // Contention: all four, back-to-back in order 0..3.
    do_reset();
    expect_b2b = 1'b1;
    expect_frame(0, 8'h11);
    expect_frame(1, 8'h22);
    expect_frame(2, 8'h4C);
    expect_frame(3, 8'h80);
    set_req(0, 8'h11);
    set_req(1, 8'h22);
    set_req(2, 8'h4C);
    set_req(3, 8'h80);
    run_traffic(1200);

    // Wrap: last grant 2, then 1001 pending -> 3 then 0.
    do_reset();
    expect_b2b = 1'b1;
    expect_frame(2, 8'h3C);
    set_req(2, 8'h3C);
    @(negedge clk);
    req_valid &= ~req_ready;
    repeat (20) @(negedge clk);
    expect_frame(3, 8'h7E);
    expect_frame(0, 8'h81);
    set_req(0, 8'h81);
    set_req(3, 8'h7E);
    run_traffic(900);

    // Withdrawn request while busy is never served.
    do_reset();
    expect_frame(0, 8'h55);
    set_req(0, 8'h55);
    @(negedge clk);
    req_valid &= ~req_ready;
    repeat (30) @(negedge clk);
    set_req(1, 8'hEE);
    @(negedge clk);
    req_valid[1] = 1'b0;
    run_traffic(400);
    repeat (20) @(negedge clk);

    // Reset during data bit 4 (0x2F has bit 4 = 0): aborted, never resent.
    do_reset();
    exp_grant.push_back(1);
    set_req(1, 8'h2F);
    @(negedge clk);
    req_valid &= ~req_ready;
    repeat (87) @(negedge clk);
    check("bit4_level", tx, 0);
    do_reset();
    repeat (40) @(negedge clk);
    expect_frame(0, 8'h12);
    expect_frame(1, 8'h34);
    set_req(0, 8'h12);
    set_req(1, 8'h34);
    run_traffic(800);

    // Tick held low freezes the line; single requester served repeatedly.
    do_reset();
    expect_frame(2, 8'hC3);
    set_req(2, 8'hC3);
    @(negedge clk);
    req_valid &= ~req_ready;
    repeat (40) @(negedge clk);
    tick = 1'b0;
    tx_hold = tx;
    hold_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== tx_hold || busy !== 1'b1) hold_bad++;
    end
    check("tick_low_hold", hold_bad, 0);
    tick = 1'b1;
    run_traffic(400);
    expect_frame(2, 8'h3D);
    set_req(2, 8'h3D);
    run_traffic(400);

`ifdef UART_ARB_PARITY_EN
    do_reset();
    expect_frame(3, 8'h07);
    set_req(3, 8'h07);
    run_traffic(400);
`endif

    repeat (5) @(negedge clk);
    check("grants_left", exp_grant.size(), 0);
    check("frames_left", exp_byte.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
